// File: rtl/ysyx_22040895_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ysyx_22040895_mdu : iterative RV64M MUL/MULW/DIVW/REMW unit              |
// | (shift-add multiplier, restoring divider, valid/ready handshakes)        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ysyx_22040895_mdu #(
    parameter int XLEN      = 64,
    parameter int MUL_STEPS = 64,
    parameter int W_STEPS   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      mduop_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int         c_CNT_W   = $clog2(MUL_STEPS + 1);
    localparam logic [3:0] c_OP_MUL  = 4'b0001;
    localparam logic [3:0] c_OP_MULW = 4'b0101;
    localparam logic [3:0] c_OP_DIVW = 4'b1001;
    localparam logic [3:0] c_OP_REMW = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;

    logic [3:0]            r_op;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]     r_acc;
    logic [2*XLEN-1:0]     r_mcand;
    logic [XLEN-1:0]       r_mplier;
    logic [31:0]           r_quo;
    logic [31:0]           r_rem;
    logic [31:0]           r_dvs;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [XLEN-1:0]       r_result;

    logic                  w_op_mul;
    logic                  w_op_mulw;
    logic                  w_op_divw;
    logic                  w_op_remw;
    logic                  w_op_div;
    logic                  w_op_undef;
    logic                  w_dvs_zero;
    logic                  w_div_ovf;
    logic                  w_special;
    logic                  w_accept;
    logic                  w_last;
    logic [XLEN-1:0]       w_special_res;

    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [31:0]           w_a_mag;
    logic [31:0]           w_b_mag;

    logic [2*XLEN-1:0]     w_acc_nx;
    logic [32:0]           w_rem_sh;
    logic [32:0]           w_diff;
    logic                  w_ge;
    logic [31:0]           w_rem_nx;
    logic [31:0]           w_quo_nx;
    logic [31:0]           w_q_fix;
    logic [31:0]           w_r_fix;

    // ---------------- request decode ----------------
    assign w_op_mul   = (mduop_i == c_OP_MUL);
    assign w_op_mulw  = (mduop_i == c_OP_MULW);
    assign w_op_divw  = (mduop_i == c_OP_DIVW);
    assign w_op_remw  = (mduop_i == c_OP_REMW);
    assign w_op_div   = w_op_divw | w_op_remw;
    assign w_op_undef = mduop_i[0] & ~(w_op_mul | w_op_mulw | w_op_div);

    assign w_dvs_zero = (src2_i[31:0] == 32'h0000_0000);
    assign w_div_ovf  = (src1_i[31:0] == 32'h8000_0000) && (src2_i[31:0] == 32'hFFFF_FFFF);
    assign w_special  = w_op_undef | (w_op_div & (w_dvs_zero | w_div_ovf));

    // Flush takes priority over a request presented in the same cycle.
    assign w_accept   = in_valid_i & (r_state == S_IDLE) & mduop_i[0] & ~flush_i;
    assign w_last     = (r_cnt == c_CNT_W'(1));

    always_comb begin
        w_special_res = '0;
        if (w_op_div && w_dvs_zero) begin
            w_special_res = w_op_divw ? '1 : {{(XLEN-32){src1_i[31]}}, src1_i[31:0]};
        end else if (w_op_div && w_div_ovf) begin
            w_special_res = w_op_divw ? {{(XLEN-32){1'b1}}, 32'h8000_0000} : '0;
        end
    end

    // Sign handling happens only here and at result fix-up; the iteration is unsigned.
    assign w_a_neg = src1_i[31];
    assign w_b_neg = src2_i[31];
    assign w_a_mag = w_a_neg ? (32'd0 - src1_i[31:0]) : src1_i[31:0];
    assign w_b_mag = w_b_neg ? (32'd0 - src2_i[31:0]) : src2_i[31:0];

    // ---------------- iteration datapath ----------------
    assign w_acc_nx = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_ge     = ~w_diff[32];
    assign w_rem_nx = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
    assign w_quo_nx = {r_quo[30:0], w_ge};
    assign w_q_fix  = r_neg_q ? (32'd0 - w_quo_nx) : w_quo_nx;
    assign w_r_fix  = r_neg_r ? (32'd0 - w_rem_nx) : w_rem_nx;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_special) begin
                        w_state_nx = S_DONE;
                    end else if (w_op_div) begin
                        w_state_nx = S_DIV;
                    end else begin
                        w_state_nx = S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (flush_i) begin
            w_state_nx = S_IDLE;
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign result_o    = r_result;

    // ---------------- operand latch, iteration and result ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op    <= mduop_i;
            r_acc   <= '0;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_op_mulw) begin
                r_mcand  <= {{(2*XLEN-32){1'b0}}, src1_i[31:0]};
                r_mplier <= {{(XLEN-32){1'b0}}, src2_i[31:0]};
            end else begin
                r_mcand  <= {{XLEN{1'b0}}, src1_i};
                r_mplier <= src2_i;
            end
            if (w_special) begin
                r_cnt    <= '0;
                r_result <= w_special_res;
            end else if (w_op_mul) begin
                r_cnt <= c_CNT_W'(MUL_STEPS);
            end else begin
                r_cnt <= c_CNT_W'(W_STEPS);
            end
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nx;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
            if (w_last) begin
                r_result <= (r_op == c_OP_MULW) ? {{(XLEN-32){w_acc_nx[31]}}, w_acc_nx[31:0]}
                                                : w_acc_nx[XLEN-1:0];
            end
        end else if (r_state == S_DIV) begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_result <= (r_op == c_OP_REMW) ? {{(XLEN-32){w_r_fix[31]}}, w_r_fix}
                                                : {{(XLEN-32){w_q_fix[31]}}, w_q_fix};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040895_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ysyx_22040895_mdu : self-checking bench for the RV64M MDU             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ysyx_22040895_mdu;

    logic        clk;
    logic        rst;
    logic [3:0]  mduop_i;
    logic [63:0] src1_i;
    logic [63:0] src2_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] result_o;
    logic        busy_o;

    int          n_checks;
    int          n_fail;
    int          ncyc;
    int          done_ncyc;
    bit          pend;
    bit          mon_en;
    logic [63:0] exp_res;

    ysyx_22040895_mdu #(
        .XLEN      (64),
        .MUL_STEPS (64),
        .W_STEPS   (32)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .mduop_i     (mduop_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (RISC-V M semantics) ----------------
    function automatic bit is_special(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bit is_div;
        bit is_mul;
        is_div = (op == 4'b1001) || (op == 4'b1101);
        is_mul = (op == 4'b0001) || (op == 4'b0101);
        if (!is_div && !is_mul) return 1'b1;
        return is_div && ((b[31:0] == 32'd0) || (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF));
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        if (is_special(op, a, b)) return 1;
        if (op == 4'b0001) return 65;
        return 33;
    endfunction

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int          sa;
        int          sb;
        int          t;
        longint      r;
        logic [63:0] p;
        bit          ovf;
        sa  = a[31:0];
        sb  = b[31:0];
        ovf = (a[31:0] == 32'h8000_0000) && (sb == -1);
        r   = 0;
        case (op)
            4'b0001: r = a * b;
            4'b0101: begin
                p = {32'd0, a[31:0]} * {32'd0, b[31:0]};
                t = p[31:0];
                r = t;
            end
            4'b1001: begin
                if (sb == 0)  t = -1;
                else if (ovf) t = sa;
                else          t = sa / sb;
                r = t;
            end
            4'b1101: begin
                if (sb == 0)  t = sa;
                else if (ovf) t = 0;
                else          t = sa % sb;
                r = t;
            end
            default: r = 0;
        endcase
        return r;
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        ncyc++;
        if (rst && mon_en) begin
            chk("busy_o",      {63'd0, busy_o},      {63'd0, pend});
            chk("in_ready_o",  {63'd0, in_ready_o},  {63'd0, !pend});
            chk("out_valid_o", {63'd0, out_valid_o}, {63'd0, (pend && ncyc >= done_ncyc)});
            if (pend && ncyc >= done_ncyc) chk("result_o", result_o, exp_res);
        end
    end

    // Present a request, scramble inputs while busy, then complete the handshake.
    task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input int hold, input bit use_lit, input logic [63:0] lit, input int lit_lat);
        int lat;
        @(negedge clk);
        mduop_i = op; src1_i = a; src2_i = b; in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk);
        exp_res   = ref_result(op, a, b);
        done_ncyc = ncyc + ref_lat(op, a, b);
        pend      = 1'b1;
        lat       = use_lit ? lit_lat : ref_lat(op, a, b);
        #1;
        src1_i  = {$urandom, $urandom};
        src2_i  = {$urandom, $urandom};
        mduop_i = 4'($urandom_range(0, 15)) | 4'b0001;
        if (use_lit && lat > 1) begin
            repeat (lat - 1) @(negedge clk);
            chk("valid_before_latency", {63'd0, out_valid_o}, 64'd0);
        end else begin
            repeat (lat - 1) @(negedge clk);
        end
        @(negedge clk);
        if (use_lit) begin
            chk("valid_at_latency", {63'd0, out_valid_o}, 64'd1);
            chk("result_literal", result_o, lit);
        end
        repeat (hold) @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk);
        pend = 1'b0;
        #1;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
    endtask

    // Accept a request and flush it k cycles later (optionally with out_ready).
    task automatic do_flush(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                            input int k, input bit with_ready);
        @(negedge clk);
        mduop_i = op; src1_i = a; src2_i = b; in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk);
        exp_res   = ref_result(op, a, b);
        done_ncyc = ncyc + ref_lat(op, a, b);
        pend      = 1'b1;
        #1;
        in_valid_i = 1'b0;
        repeat (k) @(negedge clk);
        flush_i     = 1'b1;
        out_ready_i = with_ready;
        @(posedge clk);
        pend = 1'b0;
        #1;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
    endtask

    task automatic rand_operands(output logic [63:0] a, output logic [63:0] b);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: b[31:0] = 32'd0;
            1: begin a[31:0] = 32'h8000_0000; b[31:0] = 32'hFFFF_FFFF; end
            2: begin a[31:0] = $urandom_range(0, 100); b[31:0] = $urandom_range(1, 9); end
            3: b[31:0] = 32'hFFFF_FFFF - $urandom_range(0, 8);
            default: ;
        endcase
    endtask

    initial begin
        logic [3:0]  ops [5];
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        n_checks = 0; n_fail = 0; ncyc = 0; done_ncyc = 0;
        pend = 1'b0; mon_en = 1'b0; exp_res = '0;
        rst = 1'b0; mduop_i = '0; src1_i = '0; src2_i = '0;
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        ops[0] = 4'b0001; ops[1] = 4'b0101; ops[2] = 4'b1001; ops[3] = 4'b1101; ops[4] = 4'b0011;

        #12;
        chk("reset_in_ready",  {63'd0, in_ready_o},  64'd1);
        chk("reset_busy",      {63'd0, busy_o},      64'd0);
        chk("reset_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("reset_result",    result_o,             64'd0);
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Directed cases with hand-computed results and latencies
        do_op(4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        do_op(4'b0001, 64'd3, 64'd5, 2, 1, 64'd15, 65);
        do_op(4'b0101, 64'hABCD_0000_7FFF_FFFF, 64'h1234_5678_0000_0002, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        do_op(4'b1001, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        do_op(4'b1101, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        do_op(4'b1101, 64'd100, 64'h0000_0000_FFFF_FFF9, 0, 1, 64'd2, 33);
        do_op(4'b1001, 64'd1234, 64'h0000_0007_0000_0000, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op(4'b1101, 64'd5, 64'd0, 0, 1, 64'd5, 1);
        do_op(4'b1101, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 1, 64'd0, 1);
        do_op(4'b1001, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 64'hFFFF_FFFF_8000_0000, 1);
        do_op(4'b1011, 64'h55, 64'h66, 0, 1, 64'd0, 1);
        do_op(4'b1001, 64'd100, 64'd7, 10, 1, 64'd14, 33);

        // Even opcode with valid is ignored
        @(negedge clk);
        mduop_i = 4'b0100; in_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        in_valid_i = 1'b0;

        // Flush mid-MUL, flush with out_ready in DONE, flush beating an accept
        do_flush(4'b0001, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 20, 1'b0);
        do_flush(4'b1001, 64'd77, 64'd5, 33, 1'b1);
        @(negedge clk);
        mduop_i = 4'b0001; in_valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_beats_accept", {63'd0, busy_o}, 64'd0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        mduop_i = 4'b1001; src1_i = 64'd999; src2_i = 64'd7; in_valid_i = 1'b1;
        @(posedge clk);
        exp_res = ref_result(4'b1001, 64'd999, 64'd7);
        done_ncyc = ncyc + 33;
        pend = 1'b1;
        #1 in_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        pend = 1'b0;
        #1;
        chk("rst_mid_busy",      {63'd0, busy_o},      64'd0);
        chk("rst_mid_in_ready",  {63'd0, in_ready_o},  64'd1);
        chk("rst_mid_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_mid_result",    result_o,             64'd0);
        @(negedge clk);
        #2 rst = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 4)];
            if (op == 4'b0011) op = 4'($urandom_range(0, 3) * 4 + 3);
            rand_operands(a, b);
            if ($urandom_range(0, 7) == 0) begin
                do_flush(op, a, b, $urandom_range(0, ref_lat(op, a, b)), 1'($urandom_range(0, 1)));
            end else begin
                do_op(op, a, b, $urandom_range(0, 3), 1'b0, 64'd0, 0);
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
